// File: rtl/jk_excitation_driver.sv
`default_nettype none
// ============================================================================
//  Module   : jk_excitation_driver
//  Brief    : Drives a bank of JK flip-flops to a target state. Computes the
//             J/K excitation, verifies Q feedback, retries, and flags errors.
//  Revision : 1.0  initial release
// ============================================================================
module jk_excitation_driver #(
  parameter int WIDTH      = 4,
  parameter int MAX_TRIES  = 3,
  parameter bit USE_TOGGLE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tgt,
  input  logic             load,
  input  logic [WIDTH-1:0] q_fb,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             done,
  output logic             err
);

  localparam logic [2:0] c_max_tries = 3'(MAX_TRIES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_tgt;
  logic [2:0]       r_try;

  logic [WIDTH-1:0] w_tgt_src;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;

  // On the loading edge tgt_reg is not yet valid, so excite from the live TGT.
  assign w_tgt_src = (r_state == IDLE) ? tgt : r_tgt;
  assign w_diff    = q_fb ^ w_tgt_src;

  generate
    if (USE_TOGGLE) begin : g_toggle
      assign w_j = w_diff;
      assign w_k = w_diff;
    end else begin : g_setreset
      assign w_j = w_diff & w_tgt_src;
      assign w_k = w_diff & ~w_tgt_src;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_tgt   <= '0;
      r_try   <= 3'd0;
      j       <= '0;
      k       <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      ready   <= 1'b1;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load) begin
            r_tgt   <= tgt;
            r_try   <= 3'd1;
            j       <= w_j;
            k       <= w_k;
            busy    <= 1'b1;
            ready   <= 1'b0;
            r_state <= DRIVE;
          end
        end
        DRIVE: begin
          j       <= '0;
          k       <= '0;
          r_state <= SETTLE;
        end
        SETTLE: begin
          r_state <= CHECK;
        end
        CHECK: begin
          if (q_fb == r_tgt) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            ready   <= 1'b1;
            r_state <= IDLE;
          end else if (r_try == c_max_tries) begin
            err     <= 1'b1;
            busy    <= 1'b0;
            ready   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_try   <= r_try + 3'd1;
            j       <= w_j;
            k       <= w_k;
            r_state <= DRIVE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jk_excitation_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jk_excitation_driver
//  Brief    : Directed bench with negedge JK flip-flop models for both modes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jk_excitation_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] tgt = 4'd0;
  logic       load0 = 1'b0, load1 = 1'b0;
  logic [3:0] q0 = 4'd0, q1 = 4'd0;
  logic [3:0] q_fb0, q_fb1;
  logic       stuck = 1'b0;
  logic       pl0 = 1'b0, pl1 = 1'b0;
  logic [3:0] pl_val = 4'd0;
  logic       sel = 1'b0;

  logic       ready0, busy0, done0, err0, ready1, busy1, done1, err1;
  logic [3:0] j0, k0, j1, k1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  jk_excitation_driver #(.WIDTH(4), .MAX_TRIES(3), .USE_TOGGLE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .tgt(tgt), .load(load0), .q_fb(q_fb0),
    .ready(ready0), .busy(busy0), .j(j0), .k(k0), .done(done0), .err(err0));

  jk_excitation_driver #(.WIDTH(4), .MAX_TRIES(3), .USE_TOGGLE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tgt(tgt), .load(load1), .q_fb(q_fb1),
    .ready(ready1), .busy(busy1), .j(j1), .k(k1), .done(done1), .err(err1));

  // Flip-flop bank models: sample J/K on the falling edge; bit0 of bank 0 can be stuck at 0.
  assign q_fb0 = stuck ? (q0 & 4'b1110) : q0;
  assign q_fb1 = q1;

  always @(negedge clk) begin
    if (pl0) q0 <= pl_val;
    else     q0 <= (j0 & ~q0) | (~k0 & q0);
    if (pl1) q1 <= pl_val;
    else     q1 <= (j1 & ~q1) | (~k1 & q1);
  end

  wire [3:0] m_j     = sel ? j1 : j0;
  wire [3:0] m_k     = sel ? k1 : k0;
  wire [3:0] m_q     = sel ? q_fb1 : q_fb0;
  wire       m_done  = sel ? done1 : done0;
  wire       m_err   = sel ? err1 : err0;
  wire       m_busy  = sel ? busy1 : busy0;
  wire       m_ready = sel ? ready1 : ready0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic preload(input logic s, input logic [3:0] v);
    sel    = s;
    pl_val = v;
    if (s) pl1 = 1'b1; else pl0 = 1'b1;
    @(negedge clk);
    #1;
    pl0 = 1'b0;
    pl1 = 1'b0;
  endtask

  // Returns just after e0 with LOAD already dropped.
  task automatic issue(input logic [3:0] t);
    @(posedge clk);
    #1;
    tgt = t;
    if (sel) load1 = 1'b1; else load0 = 1'b1;
    @(posedge clk);
    #1;
    load0 = 1'b0;
    load1 = 1'b0;
  endtask

  typedef struct {
    logic       tog;
    logic [3:0] q;
    logic [3:0] t;
    logic [3:0] ej;
    logic [3:0] ek;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b0, 4'b1100, 4'b0110, 4'b0010, 4'b1000};
    vecs[1] = '{1'b0, 4'b1010, 4'b1010, 4'b0000, 4'b0000};
    vecs[2] = '{1'b0, 4'b0000, 4'b1111, 4'b1111, 4'b0000};
    vecs[3] = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b1111};
    vecs[4] = '{1'b0, 4'b0101, 4'b1010, 4'b1010, 4'b0101};
    vecs[5] = '{1'b1, 4'b1100, 4'b0110, 4'b1010, 4'b1010};
    vecs[6] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

    // Reset state
    #12;
    chk("rst_ready", {31'd0, ready0}, 32'd1);
    chk("rst_busy",  {31'd0, busy0},  32'd0);
    chk("rst_j",     {28'd0, j0},     32'd0);
    chk("rst_done",  {31'd0, done0},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: each vector runs one full DRIVE/SETTLE/CHECK pass
    for (int i = 0; i < 7; i++) begin
      preload(vecs[i].tog, vecs[i].q);
      issue(vecs[i].t);
      chk("drive_busy", {31'd0, m_busy}, 32'd1);
      chk("drive_j", {28'd0, m_j}, {28'd0, vecs[i].ej});
      chk("drive_k", {28'd0, m_k}, {28'd0, vecs[i].ek});
      @(posedge clk); #1;
      chk("settle_j", {28'd0, m_j}, 32'd0);
      chk("settle_k", {28'd0, m_k}, 32'd0);
      @(posedge clk); #1;
      chk("check_done_early", {31'd0, m_done}, 32'd0);
      @(posedge clk); #1;
      chk("e3_done",  {31'd0, m_done},  32'd1);
      chk("e3_err",   {31'd0, m_err},   32'd0);
      chk("e3_ready", {31'd0, m_ready}, 32'd1);
      chk("e3_q",     {28'd0, m_q},     {28'd0, vecs[i].t});
      @(posedge clk); #1;
      chk("e4_done",  {31'd0, m_done},  32'd0);
    end

    // Stuck bit0: three attempts, ERR only at e9
    preload(1'b0, 4'b0000);
    stuck = 1'b1;
    issue(4'b0001);
    for (int c = 0; c <= 9; c++) begin
      if (c % 3 == 0 && c < 9) begin
        chk("stuck_j", {28'd0, j0}, 32'd1);
        chk("stuck_k", {28'd0, k0}, 32'd0);
      end
      chk("stuck_err",  {31'd0, err0},  {31'd0, (c == 9)});
      chk("stuck_done", {31'd0, done0}, 32'd0);
      if (c < 9) begin @(posedge clk); #1; end
    end
    chk("stuck_ready", {31'd0, ready0}, 32'd1);
    @(posedge clk); #1;
    chk("stuck_err_gone", {31'd0, err0}, 32'd0);
    stuck = 1'b0;

    // Asynchronous reset in mid-DRIVE
    preload(1'b0, 4'b0000);
    issue(4'b0011);
    chk("rstmid_j_before", {28'd0, j0}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_j",     {28'd0, j0},     32'd0);
    chk("rstmid_k",     {28'd0, k0},     32'd0);
    chk("rstmid_busy",  {31'd0, busy0},  32'd0);
    chk("rstmid_ready", {31'd0, ready0}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("rstmid_no_done", {31'd0, done0}, 32'd0);
      chk("rstmid_no_err",  {31'd0, err0},  32'd0);
      chk("rstmid_idle",    {31'd0, busy0}, 32'd0);
    end

    // LOAD during SETTLE is ignored
    preload(1'b0, 4'b0000);
    issue(4'b0011);
    @(posedge clk); #1;
    tgt   = 4'b1111;
    load0 = 1'b1;
    @(posedge clk); #1;
    load0 = 1'b0;
    @(posedge clk); #1;
    chk("busyload_done", {31'd0, done0}, 32'd1);
    chk("busyload_q",    {28'd0, q_fb0}, 32'd3);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("busyload_idle", {31'd0, busy0}, 32'd0);
      chk("busyload_once", {31'd0, done0}, 32'd0);
      chk("busyload_qhold", {28'd0, q_fb0}, 32'd3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/jk_excitation_driver.md
# jk_excitation_driver

Sequential controller that drives a bank of WIDTH JK flip-flops to a requested target state. It computes J/K excitation from the flip-flops' present outputs and holds the drive through the flip-flops' falling-edge sample. It then checks the fed-back Q against the target, retrying up to MAX_TRIES times before flagging an error. It is the producer side of the JK flip-flop interface: it generates J/K, and the flip-flop bank consumes them.

## Interface
- WIDTH, 4, number of JK flip-flops driven (1..16)
- MAX_TRIES, 3, drive attempts before ERR (1..7)
- USE_TOGGLE, 0, when 1, differing bits are driven with J=K=1 (toggle) instead of set/reset
- CLK  in  1  system clock; this block acts on the rising edge, and the flip-flop bank samples on the falling edge
- RST_N  in  1  asynchronous, active-low reset
- TGT  in  WIDTH  requested flip-flop state, sampled with LOAD
- LOAD  in  1  request strobe, accepted only when READY=1
- Q_FB  in  WIDTH  present Q outputs of the flip-flop bank, same clock domain
- READY  out  1  high in IDLE
- BUSY  out  1  high in DRIVE, SETTLE and CHECK
- J  out  WIDTH  J inputs to the flip-flop bank
- K  out  WIDTH  K inputs to the flip-flop bank
- DONE  out  1  one-cycle pulse: Q_FB matched the target
- ERR  out  1  one-cycle pulse: MAX_TRIES attempts failed

## Operation
- States: IDLE, DRIVE, SETTLE, CHECK.
- Internal registers: tgt_reg (WIDTH bits) and try_cnt (3 bits).
- IDLE:
  - J=K=0, READY=1.
  - On a rising edge with LOAD=1: tgt_reg<=TGT, try_cnt<=1, go to DRIVE.
- DRIVE (one cycle), with J/K registered from Q_FB and tgt_reg on the entering edge. Per bit, with USE_TOGGLE=0:
  - q=0, t=0: J=0, K=0.
  - q=0, t=1: J=1, K=0.
  - q=1, t=0: J=0, K=1.
  - q=1, t=1: J=0, K=0.
  - With USE_TOGGLE=1, every differing bit gets J=1, K=1; equal bits get J=0, K=0.
  - All don't-care excitations are driven as 0, never X.
- SETTLE (one cycle): J=K=0 (hold), which gives Q_FB a full cycle after the falling-edge sample.
- CHECK (one cycle): on the next rising edge:
  - If Q_FB==tgt_reg: DONE<=1, go to IDLE.
  - Else if try_cnt==MAX_TRIES: ERR<=1, go to IDLE.
  - Else: try_cnt<=try_cnt+1, go to DRIVE with J/K recomputed from the current Q_FB.
- LOAD while BUSY is ignored, and TGT is not resampled.
- A target equal to the present Q still runs one DRIVE/SETTLE/CHECK pass, with J=K=0 throughout, and ends in DONE.
- DONE and ERR are mutually exclusive. Each is high for exactly one cycle, coincident with the first IDLE cycle.
- Back-to-back operation: LOAD may be sampled on the edge immediately after DONE/ERR (READY is already 1).

## Timing
- All outputs are registered and change only on rising CLK edges, except during reset.
- J/K are therefore stable from one rising edge to the next, covering the flip-flop bank's falling-edge sample with a half-cycle of setup.
- Reset: while RST_N=0, outputs are J=0, K=0, DONE=0, ERR=0, BUSY=0, READY=1. State is IDLE, tgt_reg=0, try_cnt=0.
- Reset assertion mid-operation clears everything immediately (asynchronous), with no DONE/ERR.
- Reset release: LOAD is first honoured on the first rising edge with RST_N=1.
- Latency, counting the LOAD-sampling edge as e0:
  - DRIVE runs e0-e1, SETTLE e1-e2, CHECK e2-e3.
  - DONE/ERR is high e3-e4.
  - Each retry adds 3 cycles, so the worst-case ERR is at e(3*MAX_TRIES).

## Test plan
- Reset: RST_N low in mid-DRIVE with J=4'b0011 -> J=K=0, BUSY=0, READY=1 within the same cycle; no DONE/ERR after release.
- Set/reset encoding: bench uses a standard negedge JK model with Q=4'b1100, TGT=4'b0110, LOAD.
  - Required in DRIVE: J=4'b0010, K=4'b1000.
  - Required at e3: DONE=1, Q=4'b0110.
- Toggle mode: USE_TOGGLE=1, Q=4'b1100, TGT=4'b0110 -> in DRIVE J=K=4'b1010; DONE at e3.
- Stuck bit: model bit0 stuck at 0, TGT=4'b0001, MAX_TRIES=3.
  - Required: three DRIVE phases, each with J=4'b0001.
  - Required: ERR=1 only at e9, DONE never asserted, READY=1 afterwards.
- Already at target: Q=4'b1010, TGT=4'b1010 -> J=K=0 every cycle; DONE at e3.
- Busy LOAD: a second LOAD with TGT=4'b1111 during SETTLE is ignored -> the first target completes with one DONE, and no second operation starts.
